intdiv_seq_restoring: RTL and testbench

Sequential radix-2 restoring integer divider. It takes a LOGA+LOGB-bit dividend, typically a product C emitted by the integer multipliers, and divides it by a LOGB-bit divisor. It returns the full quotient and the remainder, so it serves as the reference reduction path and the checker-side inverse of the intmul family. It processes one operation at a time, with a valid/ready handshake on both sides and a fixed, data-independent latency.

---
 rtl/intdiv_seq_restoring.sv | 104 ++++++++++
 tb/tb_intdiv_seq_restoring.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/intdiv_seq_restoring.sv
// Sequential radix-2 restoring divider: (LOGA+LOGB)-bit dividend / LOGB-bit divisor,
// one quotient bit per clock, fixed LOGA+LOGB cycle latency, valid/ready on both sides.
`default_nettype none

module intdiv_seq_restoring #(
  parameter int LOGA = 60,
  parameter int LOGB = 60
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LOGA+LOGB-1:0] N,
  input  logic [LOGB-1:0]      D,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LOGA+LOGB-1:0] Q,
  output logic [LOGB-1:0]      R,
  output logic                 div0
);

  localparam int W   = LOGA + LOGB;
  localparam int LAT = W;
  localparam int CW  = $clog2(LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LAT);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    qreg;
  logic [LOGB-1:0] rem;
  logic [LOGB-1:0] dreg;
  logic [LOGB-1:0] nlow;
  logic [CW-1:0]   cnt;

  // Trial remainder carries one extra bit so the shifted value never overflows.
  logic [LOGB:0] t;
  logic [LOGB:0] diff;
  logic          ge;

  assign t    = {rem, qreg[W-1]};
  assign diff = t - {1'b0, dreg};
  assign ge   = (t >= {1'b0, dreg});

  // Divide-by-zero result is fixed by the latched flag, not by the iteration.
  assign Q = div0 ? {W{1'b1}} : qreg;
  assign R = div0 ? nlow : rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      qreg      <= '0;
      rem       <= '0;
      dreg      <= '0;
      nlow      <= '0;
      cnt       <= '0;
      div0      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            qreg     <= N;
            dreg     <= D;
            nlow     <= N[LOGB-1:0];
            rem      <= '0;
            cnt      <= LAT_C;
            div0     <= (D == '0);
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          rem  <= ge ? diff[LOGB-1:0] : t[LOGB-1:0];
          qreg <= {qreg[W-2:0], ge};
          cnt  <= cnt - ONE_C;
          if (cnt == ONE_C) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_intdiv_seq_restoring.sv
// Bench for intdiv_seq_restoring: transaction-level model checked every cycle,
// plus directed cases with hand-computed literal results.
`default_nettype none

module tb_intdiv_seq_restoring;

  localparam int LOGA = 60;
  localparam int LOGB = 60;
  localparam int W    = LOGA + LOGB;
  localparam int LAT  = W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    N = '0;
  logic [LOGB-1:0] D = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [W-1:0]    Q;
  logic [LOGB-1:0] R;
  logic            div0;

  int checks = 0;
  int errors = 0;

  intdiv_seq_restoring #(.LOGA(LOGA), .LOGB(LOGB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .N(N), .D(D), .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .R(R), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: accept when idle, result appears LAT edges later, held until taken.
  logic            m_ready, m_valid, m_known, m_d0;
  int              m_wait;
  logic [W-1:0]    m_q, m_n;
  logic [LOGB-1:0] m_r, m_d;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready <= 1'b1; m_valid <= 1'b0; m_known <= 1'b1; m_wait <= 0;
      m_q <= '0; m_r <= '0; m_d0 <= 1'b0; m_n <= '0; m_d <= '0;
    end else if (m_ready && in_valid) begin
      m_ready <= 1'b0; m_known <= 1'b0; m_wait <= LAT;
      m_n <= N; m_d <= D; m_d0 <= (D == '0);
      if (D == '0) begin
        m_q <= '1;
        m_r <= N[LOGB-1:0];
      end else begin
        m_q <= N / W'(D);
        m_r <= LOGB'(N % W'(D));
      end
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) m_valid <= 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0; m_ready <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 192'(in_ready), 192'(m_ready));
    chk("out_valid", 192'(out_valid), 192'(m_valid));
    if (m_valid || m_known) begin
      chk("Q", 192'(Q), 192'(m_q));
      chk("R", 192'(R), 192'(m_r));
      chk("div0", 192'(div0), 192'(m_d0));
    end
    if (out_valid && m_valid && !m_d0) begin
      chk("inv_QD_plus_R", 192'(Q) * 192'(m_d) + 192'(R), 192'(m_n));
      chk("inv_R_lt_D", 192'(R < m_d), 192'(1));
    end
  end

  function automatic logic [W-1:0] rand_n();
    logic [127:0] v;
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    return W'(v >> $urandom_range(0, 100));
  endfunction

  // Present operands from a negedge until accepted; returns at the negedge after accept.
  task automatic send(input logic [W-1:0] n, input logic [LOGB-1:0] d);
    int c;
    c = 0;
    in_valid = 1'b1; N = n; D = d;
    while (!in_ready && c < 400) begin
      @(negedge clk); c++;
    end
    if (c >= 400) chk("accept_timeout", 192'(c), 192'(0));
    @(negedge clk);
    in_valid = 1'b0;
    N = rand_n();
    D = LOGB'({$urandom(), $urandom()});
  endtask

  task automatic wait_result(input string name, input logic [W-1:0] eq,
                             input logic [LOGB-1:0] er, input logic ed0);
    int c;
    c = 0;
    while (!out_valid && c < 200) begin
      @(negedge clk); c++;
      if (!out_valid && in_ready) chk({name, "_in_ready_low"}, 192'(in_ready), 192'(0));
    end
    chk({name, "_latency"}, 192'(c), 192'(LAT));
    chk({name, "_Q"}, 192'(Q), 192'(eq));
    chk({name, "_R"}, 192'(R), 192'(er));
    chk({name, "_div0"}, 192'(div0), 192'(ed0));
  endtask

  initial begin
    logic [W-1:0]    rn;
    logic [LOGB-1:0] rd;
    logic [W-1:0]    hq;
    logic [LOGB-1:0] hr;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", {186'(0), in_ready, out_valid, (Q == '0), (R == '0), div0, 1'b1},
        {186'(0), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
    @(negedge clk);

    send(120'hFFFFFFFFFFFFFFE_000000000000001, 60'hFFFFFFFFFFFFFFF);
    wait_result("roundtrip", 120'hFFFFFFFFFFFFFFF, 60'h0, 1'b0);
    @(negedge clk);

    send(120'd100, 60'd7);
    wait_result("small", 120'd14, 60'd2, 1'b0);
    @(negedge clk);

    send({W{1'b1}}, 60'd1);
    wait_result("d_one", {W{1'b1}}, 60'd0, 1'b0);
    @(negedge clk);

    send(120'hFFFFFFFFFFFFFFE, 60'hFFFFFFFFFFFFFFF);
    wait_result("n_lt_d", 120'd0, 60'hFFFFFFFFFFFFFFE, 1'b0);
    @(negedge clk);

    send(120'h123, 60'd0);
    wait_result("div_zero", {W{1'b1}}, 60'h123, 1'b1);
    @(negedge clk);

    // Backpressure: hold result while a new request is pending, then back-to-back.
    out_ready = 1'b0;
    send(120'd1000, 60'd3);
    wait_result("bp", 120'd333, 60'd1, 1'b0);
    in_valid = 1'b1; N = 120'd55; D = 60'd5;
    repeat (10) @(negedge clk);
    chk("bp_held_Q", 192'(Q), 192'(120'd333));
    chk("bp_held_valid", 192'(out_valid), 192'(1));
    out_ready = 1'b1;
    send(120'd9, 60'd4);
    wait_result("b2b", 120'd2, 60'd1, 1'b0);
    @(negedge clk);

    // Reset in the middle of RUN: no result may ever appear.
    send(120'd12345, 60'd11);
    repeat (49) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 10) @(negedge clk);
    chk("abort_idle", {190'(0), in_ready, out_valid}, {190'(0), 1'b1, 1'b0});

    for (int i = 0; i < 600; i++) begin
      rn = rand_n();
      rd = LOGB'({$urandom(), $urandom()} >> $urandom_range(0, 59));
      if (rd == '0) rd = 60'd1;
      out_ready = ($urandom_range(0, 3) != 0);
      send(rn, rd);
      hq = rn / W'(rd);
      hr = LOGB'(rn % W'(rd));
      wait_result("rand", hq, hr, 1'b0);
      if (!out_ready) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        out_ready = 1'b1;
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
